// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth product accumulator.
// Holds the FSM state enum, default widths and saturation bounds.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    localparam int PROD_W_DEF    = 8;
    localparam int ACC_W_DEF     = 16;
    localparam int MAX_BEATS_DEF = 16;
    localparam int CNT_W_DEF     = 5;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Bit patterns of the signed extremes for a w-bit accumulator, low w bits valid.
    function automatic logic [63:0] acc_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/booth_prod_accum_if.sv
// Product-in / sum-out handshake bundle for booth_prod_accum.
// master drives products and accepts sums; slave is the accumulator.
interface booth_prod_accum_if
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_data;
    logic [CNT_W-1:0]  sum_count;
    logic              sum_ovf;
    logic              sum_forced;

    modport master (
        output prod_valid, prod_data, prod_last, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_count, sum_ovf, sum_forced
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_count, sum_ovf, sum_forced
    );
endinterface

// File: rtl/booth_sat_add.sv
// Sign-extend a product, add it to the accumulator and flag signed overflow.
// With BOOTH_ACCUM_SAT_EN the result clamps to the signed extreme on overflow.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end else begin : g_noext
            assign ext = prod[ACC_W-1:0];
        end
    endgenerate

    assign raw = acc + ext;
    assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACCUM_SAT_EN
    // Operands share a sign on overflow, so acc's sign picks the clamp direction.
    assign sum = ovf ? (acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    logic unused_sat;
    assign unused_sat = ^{SAT_MAX, SAT_MIN};
    assign sum = raw;
`endif

endmodule

// File: rtl/booth_prod_accum.sv
// Packet accumulator for signed Booth products: one sum per packet, with valid/ready on both sides.
// Optional clamp-on-overflow arithmetic is enabled by defining BOOTH_ACCUM_SAT_EN.
module booth_prod_accum
    import booth_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    booth_prod_accum_if.slave   bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             sum_valid_q, sum_valid_d;
    logic [ACC_W-1:0] sum_data_q, sum_data_d;
    logic [CNT_W-1:0] sum_count_q, sum_count_d;
    logic             sum_ovf_q, sum_ovf_d;
    logic             sum_forced_q, sum_forced_d;

    logic [ACC_W-1:0] nxt;
    logic             ovf_now;
    logic [CNT_W-1:0] cnt_inc;
    logic             prod_ready;
    logic             beat;
    logic             close;

    booth_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc  (acc_q),
        .prod (bus.prod_data),
        .sum  (nxt),
        .ovf  (ovf_now)
    );

    assign prod_ready = (state_q != HOLD) && !clear;
    assign beat       = bus.prod_valid && prod_ready;
    assign cnt_inc    = cnt_q + 1'b1;
    assign close      = bus.prod_last || (cnt_inc == MAX_CNT);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        sum_valid_d  = sum_valid_q;
        sum_data_d   = sum_data_q;
        sum_count_d  = sum_count_q;
        sum_ovf_d    = sum_ovf_q;
        sum_forced_d = sum_forced_q;
        if (clear) begin
            state_d      = IDLE;
            acc_d        = '0;
            cnt_d        = '0;
            ovf_d        = 1'b0;
            sum_valid_d  = 1'b0;
            sum_data_d   = '0;
            sum_count_d  = '0;
            sum_ovf_d    = 1'b0;
            sum_forced_d = 1'b0;
        end else begin
            case (state_q)
                // acc/cnt are zero in IDLE, so the first beat uses the same path as later ones.
                IDLE, ACCUM: begin
                    if (beat) begin
                        if (close) begin
                            sum_valid_d  = 1'b1;
                            sum_data_d   = nxt;
                            sum_count_d  = cnt_inc;
                            sum_ovf_d    = ovf_q | ovf_now;
                            sum_forced_d = !bus.prod_last;
                            acc_d        = '0;
                            cnt_d        = '0;
                            ovf_d        = 1'b0;
                            state_d      = HOLD;
                        end else begin
                            acc_d   = nxt;
                            cnt_d   = cnt_inc;
                            ovf_d   = ovf_q | ovf_now;
                            state_d = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.sum_ready) begin
                        sum_valid_d  = 1'b0;
                        sum_data_d   = '0;
                        sum_count_d  = '0;
                        sum_ovf_d    = 1'b0;
                        sum_forced_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            sum_valid_q  <= 1'b0;
            sum_data_q   <= '0;
            sum_count_q  <= '0;
            sum_ovf_q    <= 1'b0;
            sum_forced_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            sum_valid_q  <= sum_valid_d;
            sum_data_q   <= sum_data_d;
            sum_count_q  <= sum_count_d;
            sum_ovf_q    <= sum_ovf_d;
            sum_forced_q <= sum_forced_d;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.sum_data   = sum_data_q;
    assign bus.sum_count  = sum_count_q;
    assign bus.sum_ovf    = sum_ovf_q;
    assign bus.sum_forced = sum_forced_q;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Directed bench for booth_prod_accum: a 16-bit/4-beat instance and an 8-bit overflow instance.
module tb_booth_prod_accum;

    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   failures;

    booth_prod_accum_if #(.PROD_W(8), .ACC_W(16), .CNT_W(3)) ia ();
    booth_prod_accum_if #(.PROD_W(8), .ACC_W(8),  .CNT_W(5)) ib ();

    booth_prod_accum #(.PROD_W(8), .ACC_W(16), .MAX_BEATS(4), .CNT_W(3)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ia.slave)
    );
    booth_prod_accum #(.PROD_W(8), .ACC_W(8), .MAX_BEATS(16), .CNT_W(5)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ib.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic beat_a(input logic [7:0] d, input logic last);
        ia.prod_valid = 1'b1;
        ia.prod_data  = d;
        ia.prod_last  = last;
        @(posedge clk); #1;
        ia.prod_valid = 1'b0;
        ia.prod_last  = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] d, input logic last);
        ib.prod_valid = 1'b1;
        ib.prod_data  = d;
        ib.prod_last  = last;
        @(posedge clk); #1;
        ib.prod_valid = 1'b0;
        ib.prod_last  = 1'b0;
    endtask

    task automatic drain_a();
        ia.sum_ready = 1'b1;
        @(posedge clk); #1;
        ia.sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (ia.sum_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", ia.sum_valid); end
        checks++; if (ia.sum_data !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", ia.sum_data); end
        checks++; if (ia.sum_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", ia.sum_count); end
        checks++; if ({ia.sum_ovf, ia.sum_forced} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {ia.sum_ovf, ia.sum_forced}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ia.prod_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", ia.prod_ready); end
    endtask

    task automatic test_single_beat();
        beat_a(8'hC8, 1'b1);
        checks++; if (ia.sum_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", ia.sum_valid); end
        checks++; if (ia.sum_data !== 16'hFFC8) begin failures++; $display("FAIL single_data got=%h exp=ffc8", ia.sum_data); end
        checks++; if (ia.sum_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", ia.sum_count); end
        checks++; if ({ia.sum_ovf, ia.sum_forced} !== 2'b00) begin failures++; $display("FAIL single_flags got=%b exp=00", {ia.sum_ovf, ia.sum_forced}); end
        checks++; if (ia.prod_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%0b exp=0", ia.prod_ready); end
        drain_a();
        checks++; if (ia.sum_valid !== 1'b0 || ia.prod_ready !== 1'b1) begin failures++; $display("FAIL single_drain got=%0b%0b exp=01", ia.sum_valid, ia.prod_ready); end
    endtask

    task automatic test_three_beats();
        beat_a(8'd64, 1'b0);
        beat_a(8'hC8, 1'b0);
        checks++; if (ia.sum_valid !== 1'b0) begin failures++; $display("FAIL three_early_valid got=%0b exp=0", ia.sum_valid); end
        beat_a(8'd7, 1'b1);
        checks++; if (ia.sum_valid !== 1'b1 || ia.sum_data !== 16'd15) begin failures++; $display("FAIL three_data got=%0b/%h exp=1/000f", ia.sum_valid, ia.sum_data); end
        checks++; if (ia.sum_count !== 3'd3 || ia.sum_forced !== 1'b0) begin failures++; $display("FAIL three_count got=%0d/%0b exp=3/0", ia.sum_count, ia.sum_forced); end
    endtask

    // Continues from the held sum of 15 left by test_three_beats.
    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ia.prod_ready !== 1'b0 || ia.sum_valid !== 1'b1 || ia.sum_data !== 16'd15 || ia.sum_count !== 3'd3) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%0b%0b/%h/%0d exp=01/000f/3", i, ia.prod_ready, ia.sum_valid, ia.sum_data, ia.sum_count);
            end
        end
        drain_a();
        checks++; if (ia.prod_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%0b exp=1", ia.prod_ready); end
        beat_a(8'd5, 1'b1);
        checks++; if (ia.sum_valid !== 1'b1 || ia.sum_data !== 16'd5) begin failures++; $display("FAIL bp_next got=%0b/%h exp=1/0005", ia.sum_valid, ia.sum_data); end
        drain_a();
    endtask

    task automatic test_idle_gap();
        beat_a(8'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        beat_a(8'd4, 1'b1);
        checks++; if (ia.sum_data !== 16'd7 || ia.sum_count !== 3'd2) begin failures++; $display("FAIL gap_sum got=%h/%0d exp=0007/2", ia.sum_data, ia.sum_count); end
        drain_a();
    endtask

    task automatic test_force_close();
        for (int i = 0; i < 3; i++) beat_a(8'd1, 1'b0);
        checks++; if (ia.sum_valid !== 1'b0) begin failures++; $display("FAIL force_early got=%0b exp=0", ia.sum_valid); end
        beat_a(8'd1, 1'b0);
        checks++; if (ia.sum_valid !== 1'b1 || ia.sum_data !== 16'd4) begin failures++; $display("FAIL force_data got=%0b/%h exp=1/0004", ia.sum_valid, ia.sum_data); end
        checks++; if (ia.sum_count !== 3'd4 || ia.sum_forced !== 1'b1) begin failures++; $display("FAIL force_flags got=%0d/%0b exp=4/1", ia.sum_count, ia.sum_forced); end
        drain_a();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
`ifdef BOOTH_ACCUM_SAT_EN
        exp_d = 8'h7F;
`else
        exp_d = 8'hC8;
`endif
        beat_b(8'd100, 1'b0);
        beat_b(8'd100, 1'b1);
        checks++; if (ib.sum_valid !== 1'b1 || ib.sum_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b/%0b exp=1/1", ib.sum_valid, ib.sum_ovf); end
        checks++; if (ib.sum_data !== exp_d || ib.sum_count !== 5'd2) begin failures++; $display("FAIL ovf_data got=%h/%0d exp=%h/2", ib.sum_data, ib.sum_count, exp_d); end
        ib.sum_ready = 1'b1;
        @(posedge clk); #1;
        ib.sum_ready = 1'b0;
        beat_b(8'd3, 1'b1);
        checks++; if (ib.sum_ovf !== 1'b0 || ib.sum_data !== 8'd3) begin failures++; $display("FAIL ovf_sticky_clr got=%0b/%h exp=0/03", ib.sum_ovf, ib.sum_data); end
        ib.sum_ready = 1'b1;
        @(posedge clk); #1;
        ib.sum_ready = 1'b0;
    endtask

    task automatic test_clear();
        beat_a(8'd10, 1'b0);
        clear = 1'b1;
        ia.prod_valid = 1'b1; ia.prod_data = 8'd20; ia.prod_last = 1'b1;
        #1;
        checks++; if (ia.prod_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%0b exp=0", ia.prod_ready); end
        @(posedge clk); #1;
        clear = 1'b0; ia.prod_valid = 1'b0; ia.prod_last = 1'b0;
        @(posedge clk); #1;
        checks++; if (ia.sum_valid !== 1'b0) begin failures++; $display("FAIL clr_novalid got=%0b exp=0", ia.sum_valid); end
        beat_a(8'd2, 1'b1);
        checks++; if (ia.sum_data !== 16'd2 || ia.sum_count !== 3'd1) begin failures++; $display("FAIL clr_fresh got=%h/%0d exp=0002/1", ia.sum_data, ia.sum_count); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (ia.sum_valid !== 1'b0 || ia.sum_data !== 16'd0 || ia.sum_count !== 3'd0) begin failures++; $display("FAIL clr_hold got=%0b/%h/%0d exp=0/0000/0", ia.sum_valid, ia.sum_data, ia.sum_count); end
    endtask

    task automatic test_reset_mid();
        beat_a(8'd9, 1'b0);
        beat_a(8'd9, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ia.sum_valid !== 1'b0 || ia.sum_data !== 16'd0 || ia.sum_count !== 3'd0) begin failures++; $display("FAIL rstmid_out got=%0b/%h/%0d exp=0/0000/0", ia.sum_valid, ia.sum_data, ia.sum_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat_a(8'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        beat_a(8'd6, 1'b1);
        checks++; if (ia.sum_data !== 16'd6 || ia.sum_count !== 3'd1) begin failures++; $display("FAIL rstmid_fresh got=%h/%0d exp=0006/1", ia.sum_data, ia.sum_count); end
        drain_a();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; clear = 1'b0;
        ia.prod_valid = 1'b0; ia.prod_data = '0; ia.prod_last = 1'b0; ia.sum_ready = 1'b0;
        ib.prod_valid = 1'b0; ib.prod_data = '0; ib.prod_last = 1'b0; ib.sum_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_three_beats();
        test_backpressure();
        test_idle_gap();
        test_force_close();
        test_overflow();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Downstream consumer of the 4x4 Booth multiplier's 8-bit signed product.
- Accumulates a packet of consecutive signed products into a wider signed sum, giving a dot-product / MAC stage.
- Valid/ready handshake on both sides; one sum emitted per packet.
- Sits between the multiplier output and any result sink.

Parameters:
- PROD_W, 8: product width; two's-complement signed.
- ACC_W, 16: accumulator and sum width; must be >= PROD_W.
- MAX_BEATS, 16: maximum products per packet; the packet is force-closed at this count.
- CNT_W, 5: beat counter width; must satisfy 2**CNT_W > MAX_BEATS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; drops the partial or pending sum.
- prod_valid  in  1  product beat valid.
- prod_ready  out  1  stage can accept a beat.
- prod_data  in  PROD_W  signed product.
- prod_last  in  1  final beat of the packet.
- sum_valid  out  1  sum available.
- sum_ready  in  1  sink accepts the sum.
- sum_data  out  ACC_W  signed accumulated sum.
- sum_count  out  CNT_W  number of beats in the packet.
- sum_ovf  out  1  sticky signed overflow seen during the packet.
- sum_forced  out  1  packet closed by MAX_BEATS, not by prod_last.

Behaviour:
- Reset:
  - Interface is one clock; reset is asynchronous and active-low.
  - All outputs are 0 and state is IDLE.
  - Reset may assert mid-packet; the partial sum is discarded with no output.
- prod_ready is 1 in IDLE and ACCUM, 0 in HOLD.
- A beat is taken when prod_valid && prod_ready.
- Arithmetic:
  - prod_data is sign-extended to ACC_W.
  - nxt = acc + ext. Wrap-around is two's-complement unless the saturation macro is enabled.
  - Overflow: both operands share a sign and nxt has a different sign. It sets the sticky ovf bit for the packet.
- States:
  - IDLE:
    - acc=0, cnt=0, ovf=0.
    - Beat without last -> acc=ext, cnt=1, go ACCUM.
    - Beat with last -> load the sum registers directly, go HOLD.
  - ACCUM:
    - Each beat: acc=nxt, cnt=cnt+1.
    - If prod_last, or cnt+1==MAX_BEATS: sum_data=nxt, sum_count=cnt+1, sum_forced=!prod_last, go HOLD.
  - HOLD:
    - sum_valid=1 and all sum outputs are held stable.
    - On sum_ready: sum_valid=0 on the next edge, acc/cnt/ovf cleared, go IDLE.
    - Back-to-back operation: prod_ready rises in the cycle after the sum handshake.
- Latency: the sum is valid in the cycle after the closing beat is accepted.
- Throughput: one beat per cycle while accumulating.
- clear:
  - Highest priority after reset.
  - In any state, the next edge returns to IDLE with all outputs 0.
  - A beat presented with clear is not accepted; prod_ready is forced to 0 while clear is high.
  - A pending sum in HOLD is discarded.
- Idle cycles (prod_valid=0) inside a packet leave acc unchanged.

Optional Feature:
- Macro: BOOTH_ACCUM_SAT_EN.
- Defined: on overflow, acc clamps to +(2**(ACC_W-1)-1) or -(2**(ACC_W-1)), matching the sign of the operands. Later beats add to the clamped value. sum_ovf is still reported.
- Undefined: wrap-around arithmetic; sum_ovf is reported only.
- Ports and timing are identical either way.

Decomposition:
- Shared package booth_pkg holds:
  - state enum {IDLE, ACCUM, HOLD};
  - PROD_W/ACC_W defaults;
  - the signed min/max constants used by saturation.
- One sub-module, booth_sat_add: combinational sign-extend + add + overflow detect, with saturation under the macro.
- The FSM and handshake stay in the top module.

Test Plan:
- Single beat: prod_data=8'hC8 (-56) with last -> next cycle sum_valid=1, sum_data=16'hFFC8, sum_count=1, ovf=0, forced=0.
- Three beats: 64, -56, 7 with last on the 3rd -> sum_data=15, sum_count=3.
- Backpressure: hold sum_ready=0 for 5 cycles -> prod_ready=0 and outputs stable. Then assert sum_ready -> IDLE; a beat in the next cycle is accepted.
- Force close: MAX_BEATS=4, four beats of 1 with no last -> sum_data=4, sum_count=4, sum_forced=1.
- Overflow: ACC_W=8, beats 100 and 100 -> sum_ovf=1. sum_data is -56 (8'hC8) without the macro, and 127 with BOOTH_ACCUM_SAT_EN.
- Aborts:
  - clear asserted with a prod_last beat mid-packet -> beat not accepted, no sum_valid, IDLE.
  - rst_n pulsed low mid-packet -> all outputs 0 immediately.
